// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: FSM encodings,
// default parameters and the control-strobe bundle consumed by EXM.
package interrupt_sequencer_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_SAFE  = 3'd1;
   localparam logic [2:0] ST_PUSH_PC    = 3'd2;
   localparam logic [2:0] ST_PUSH_FLAGS = 3'd3;
   localparam logic [2:0] ST_LOAD_VEC   = 3'd4;
   localparam logic [2:0] ST_SERVICE    = 3'd5;

   localparam logic [15:0] DEF_VECTOR_ADDR  = 16'h0001;
   localparam int unsigned DEF_DRAIN_CYCLES = 3;

   typedef struct packed {
      logic push_pc;
      logic push_flags;
      logic load_vector;
   } irq_ctrl_t;

endpackage

// File: rtl/interrupt_sequencer_edge_detector.sv
// Registered rising-edge detector with synchronous active-low reset.
// Edges are ignored in the first cycle after reset so a pin held high
// through reset is not mistaken for a new request.
module edge_detector (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sig,
   output logic o_edge
);

   logic sig_q, sig_d;
   logic armed_q, armed_d;

   always_comb begin
      sig_d   = i_sig;
      armed_d = 1'b1;
   end

   assign o_edge = i_sig & ~sig_q & armed_q;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         sig_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sig_q   <= sig_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// External interrupt entry: latch request, drain the pipeline, issue the
// push-PC / push-flags / load-vector strobes, then track the ISR until RTI.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | no entry in progress; leaves when a request is pending
// WAIT_SAFE   | fetch held; counting consecutive quiet pipeline cycles
// PUSH_PC     | EXM pushes the held PC
// PUSH_FLAGS  | EXM pushes Z/N/C
// LOAD_VEC    | PC loaded from mem[VECTOR_ADDR]
// SERVICE     | ISR running until RTI retires
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
#(
   parameter logic [15:0] VECTOR_ADDR  = DEF_VECTOR_ADDR,
   parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_interrupt,
   input  logic        i_stall,
   input  logic        i_ldm_busy,
   input  logic        i_branch_busy,
   input  logic        i_rti,
   output logic        o_fetch_hold,
   output logic        o_push_pc,
   output logic        o_push_flags,
   output logic        o_load_vector,
   output logic [15:0] o_vector_addr,
   output logic        o_in_service,
   output logic        o_pending
);

   localparam logic [2:0] DRAIN_TC = 3'(DRAIN_CYCLES);

   logic [2:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       pending_q, pending_d;
   logic [2:0] cnt_inc;
   logic       quiet;
   logic       int_edge;
   irq_ctrl_t  ctrl;

   edge_detector u_int_edge (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_sig   (i_interrupt),
      .o_edge  (int_edge)
   );

   assign quiet   = ~i_ldm_busy & ~i_branch_busy & ~i_stall;
   assign cnt_inc = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl    = '0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q && !i_stall) begin
               state_d = ST_WAIT_SAFE;
               cnt_d   = 3'd0;
            end
         end
         ST_WAIT_SAFE: begin
            // Any disturbance restarts the drain window from scratch.
            if (!quiet) begin
               cnt_d = 3'd0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == DRAIN_TC) state_d = ST_PUSH_PC;
            end
         end
         ST_PUSH_PC: begin
            if (!i_stall) begin
               ctrl.push_pc = 1'b1;
               state_d      = ST_PUSH_FLAGS;
            end
         end
         ST_PUSH_FLAGS: begin
            if (!i_stall) begin
               ctrl.push_flags = 1'b1;
               state_d         = ST_LOAD_VEC;
            end
         end
         ST_LOAD_VEC: begin
            if (!i_stall) begin
               ctrl.load_vector = 1'b1;
               state_d          = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            if (i_rti && !i_stall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new edge coinciding with the PC push must survive for the next entry.
   assign pending_d = int_edge | (pending_q & ~ctrl.push_pc);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   assign o_push_pc     = ctrl.push_pc;
   assign o_push_flags  = ctrl.push_flags;
   assign o_load_vector = ctrl.load_vector;
   assign o_fetch_hold  = (state_q == ST_WAIT_SAFE) || (state_q == ST_PUSH_PC) ||
                          (state_q == ST_PUSH_FLAGS) || (state_q == ST_LOAD_VEC);
   assign o_in_service  = (state_q == ST_SERVICE);
   assign o_pending     = pending_q;
   assign o_vector_addr = VECTOR_ADDR;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; one step per clock cycle with
// hand-computed output vectors {push_pc,push_flags,load_vector,fetch_hold,in_service,pending}.
module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        intr = 1'b1;
   logic        stall = 1'b0;
   logic        ldm = 1'b0;
   logic        br = 1'b0;
   logic        rti = 1'b0;
   logic        fetch_hold, push_pc, push_flags, load_vector, in_service, pending;
   logic [15:0] vector_addr;
   logic [5:0]  outs;
   int          errors = 0;
   int          checks = 0;

   interrupt_sequencer dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_interrupt   (intr),
      .i_stall       (stall),
      .i_ldm_busy    (ldm),
      .i_branch_busy (br),
      .i_rti         (rti),
      .o_fetch_hold  (fetch_hold),
      .o_push_pc     (push_pc),
      .o_push_flags  (push_flags),
      .o_load_vector (load_vector),
      .o_vector_addr (vector_addr),
      .o_in_service  (in_service),
      .o_pending     (pending)
   );

   always #5 clk = ~clk;

   assign outs = {push_pc, push_flags, load_vector, fetch_hold, in_service, pending};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive this cycle's inputs just after the rising edge, then check outputs.
   task automatic step(input string tag, input logic r, input logic i, input logic l,
                       input logic b, input logic s, input logic t, input logic [5:0] exp);
      @(posedge clk);
      #1;
      rst_n = r; intr = i; ldm = l; br = b; stall = s; rti = t;
      #1;
      check(tag, {10'd0, outs}, {10'd0, exp});
   endtask

   initial begin
      // reset held with pin high
      step("rst0",        0, 1, 0, 0, 0, 0, 6'b000000);
      step("rst1",        0, 1, 0, 0, 0, 0, 6'b000000);
      check("rst_vec", vector_addr, 16'h0001);
      step("rst2",        1, 1, 0, 0, 0, 0, 6'b000000);
      step("hi_noentry0", 1, 1, 0, 0, 0, 0, 6'b000000);
      step("hi_noentry1", 1, 1, 0, 0, 0, 0, 6'b000000);
      step("hi_noentry2", 1, 1, 0, 0, 0, 0, 6'b000000);
      step("pin_low0",    1, 0, 0, 0, 0, 0, 6'b000000);
      step("pin_low1",    1, 0, 0, 0, 0, 0, 6'b000000);

      // single edge, quiet pipeline
      step("a_edge",      1, 1, 0, 0, 0, 0, 6'b000000);
      step("a_pend",      1, 1, 0, 0, 0, 0, 6'b000001);
      step("a_wait0",     1, 1, 0, 0, 0, 0, 6'b000101);
      step("a_wait1",     1, 1, 0, 0, 0, 0, 6'b000101);
      step("a_wait2",     1, 1, 0, 0, 0, 0, 6'b000101);
      step("a_push_pc",   1, 1, 0, 0, 0, 0, 6'b100101);
      step("a_push_fl",   1, 1, 0, 0, 0, 0, 6'b010100);
      step("a_load_vec",  1, 1, 0, 0, 0, 0, 6'b001100);
      check("a_vec", vector_addr, 16'h0001);
      step("a_svc0",      1, 1, 0, 0, 0, 0, 6'b000010);
      step("a_svc_rti",   1, 1, 0, 0, 0, 1, 6'b000010);
      step("a_idle",      1, 1, 0, 0, 0, 0, 6'b000000);
      step("a_low",       1, 0, 0, 0, 0, 0, 6'b000000);

      // LDM busy restarts drain; stall delays push_flags
      step("c_edge",      1, 1, 0, 0, 0, 0, 6'b000000);
      step("c_pend",      1, 1, 0, 0, 0, 0, 6'b000001);
      step("c_ldm0",      1, 1, 1, 0, 0, 0, 6'b000101);
      step("c_ldm1",      1, 1, 1, 0, 0, 0, 6'b000101);
      step("c_q1",        1, 1, 0, 0, 0, 0, 6'b000101);
      step("c_q2",        1, 1, 0, 0, 0, 0, 6'b000101);
      step("c_q3",        1, 1, 0, 0, 0, 0, 6'b000101);
      step("c_push_pc",   1, 1, 0, 0, 0, 0, 6'b100101);
      step("c_stall_fl",  1, 1, 0, 0, 1, 0, 6'b000100);
      step("c_push_fl",   1, 1, 0, 0, 0, 0, 6'b010100);
      step("c_load_vec",  1, 1, 0, 0, 0, 0, 6'b001100);
      step("c_svc",       1, 0, 0, 0, 0, 0, 6'b000010);

      // second edge in SERVICE waits for RTI, then re-enters
      step("d_edge_svc",  1, 1, 0, 0, 0, 0, 6'b000010);
      step("d_pend_svc",  1, 1, 0, 0, 0, 0, 6'b000011);
      step("d_rti",       1, 1, 0, 0, 0, 1, 6'b000011);
      step("d_idle",      1, 1, 0, 0, 0, 0, 6'b000001);
      step("d_wait0",     1, 1, 0, 0, 0, 0, 6'b000101);
      step("d_wait_rti",  1, 1, 0, 0, 0, 1, 6'b000101);
      step("d_wait2",     1, 1, 0, 0, 0, 0, 6'b000101);
      step("d_push_pc",   1, 1, 0, 0, 0, 0, 6'b100101);
      step("d_push_fl",   1, 1, 0, 0, 0, 0, 6'b010100);
      step("d_load_vec",  1, 1, 0, 0, 0, 0, 6'b001100);
      step("d_svc",       1, 1, 0, 0, 0, 0, 6'b000010);
      step("d_rti2",      1, 0, 0, 0, 0, 1, 6'b000010);
      step("d_idle2",     1, 0, 0, 0, 0, 0, 6'b000000);

      // edge coinciding with push_pc, then reset during PUSH_FLAGS
      step("e_edge",      1, 1, 0, 0, 0, 0, 6'b000000);
      step("e_pend",      1, 1, 0, 0, 0, 0, 6'b000001);
      step("e_wait0",     1, 1, 0, 0, 0, 0, 6'b000101);
      step("e_wait1",     1, 1, 0, 0, 0, 0, 6'b000101);
      step("e_wait2",     1, 0, 0, 0, 0, 0, 6'b000101);
      step("e_pc_edge",   1, 1, 0, 0, 0, 0, 6'b100101);
      step("e_fl_rst",    0, 1, 0, 0, 0, 0, 6'b010101);
      step("e_after_rst", 1, 1, 0, 0, 0, 0, 6'b000000);
      step("e_post1",     1, 1, 0, 0, 0, 0, 6'b000000);
      step("e_post2",     1, 1, 0, 0, 0, 0, 6'b000000);
      step("e_post3",     1, 1, 0, 0, 0, 0, 6'b000000);
      check("e_vec", vector_addr, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
